// File: rtl/pc_ras.sv
// Fetch-stage program counter with a circular return-address stack,
// single-level interrupt entry/return and sticky stack error flags.
module pc_ras #(
  parameter int          AW         = 8,
  parameter int          DEPTH      = 4,
  parameter int unsigned RESET_ADDR = 0,
  parameter int unsigned IRQ_VEC    = 32'hF0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en,
  input  logic                       load,
  input  logic                       imm,
  input  logic                       call,
  input  logic                       ret,
  input  logic                       reti,
  input  logic                       irq_req,
  input  logic                       clr_err,
  input  logic [AW-1:0]              target,
  output logic [AW-1:0]              pc,
  output logic [$clog2(DEPTH+1)-1:0] ras_count,
  output logic                       ras_empty,
  output logic                       ras_full,
  output logic                       in_isr,
  output logic                       irq_ack,
  output logic                       ovf,
  output logic                       unf
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [AW-1:0] RESET_PC = AW'(RESET_ADDR);
  localparam logic [AW-1:0] IRQ_PC   = AW'(IRQ_VEC);

  logic [AW-1:0] stack_mem [DEPTH];

  logic [AW-1:0] pc_reg, pc_next;
  logic [PW-1:0] top_reg, top_next;
  logic [CW-1:0] count_reg, count_next;
  logic          in_isr_reg, in_isr_next;
  logic          irq_ack_reg, irq_ack_next;
  logic          ovf_reg, ovf_next;
  logic          unf_reg, unf_next;

  logic [AW-1:0] seq;
  logic [PW-1:0] ptr_inc, ptr_dec;
  logic          stack_full, stack_empty;
  logic          push, pop, ovf_set, unf_set;
  logic [AW-1:0] push_data;

  assign seq         = pc_reg + (imm ? AW'(2) : AW'(1));
  // top_reg addresses the next free slot; wrapping it when full overwrites the oldest entry
  assign ptr_inc     = (top_reg == PW'(DEPTH-1)) ? '0 : top_reg + PW'(1);
  assign ptr_dec     = (top_reg == '0) ? PW'(DEPTH-1) : top_reg - PW'(1);
  assign stack_full  = (count_reg == CW'(DEPTH));
  assign stack_empty = (count_reg == '0);

  always_comb begin
    pc_next      = pc_reg;
    top_next     = top_reg;
    count_next   = count_reg;
    in_isr_next  = in_isr_reg;
    irq_ack_next = 1'b0;
    push         = 1'b0;
    pop          = 1'b0;
    push_data    = '0;
    ovf_set      = 1'b0;
    unf_set      = 1'b0;

    if (en) begin
      if (irq_req && !in_isr_reg) begin
        push         = 1'b1;
        push_data    = pc_reg;
        pc_next      = IRQ_PC;
        in_isr_next  = 1'b1;
        irq_ack_next = 1'b1;
      end else if (reti || ret) begin
        pop = 1'b1;
        if (reti) in_isr_next = 1'b0;
      end else if (call) begin
        push      = 1'b1;
        push_data = seq;
        pc_next   = target;
      end else if (load) begin
        pc_next = target;
      end else begin
        pc_next = seq;
      end
    end

    if (push) begin
      top_next = ptr_inc;
      if (stack_full) ovf_set = 1'b1;
      else            count_next = count_reg + CW'(1);
    end

    // An empty pop behaves as a NOP on the PC
    if (pop) begin
      if (stack_empty) begin
        unf_set = 1'b1;
        pc_next = seq;
      end else begin
        pc_next    = stack_mem[ptr_dec];
        top_next   = ptr_dec;
        count_next = count_reg - CW'(1);
      end
    end

    ovf_next = (ovf_reg & ~clr_err) | ovf_set;
    unf_next = (unf_reg & ~clr_err) | unf_set;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_reg      <= RESET_PC;
      top_reg     <= '0;
      count_reg   <= '0;
      in_isr_reg  <= 1'b0;
      irq_ack_reg <= 1'b0;
      ovf_reg     <= 1'b0;
      unf_reg     <= 1'b0;
    end else begin
      pc_reg      <= pc_next;
      top_reg     <= top_next;
      count_reg   <= count_next;
      in_isr_reg  <= in_isr_next;
      irq_ack_reg <= irq_ack_next;
      ovf_reg     <= ovf_next;
      unf_reg     <= unf_next;
    end
  end

  always_ff @(posedge clk) begin
    if (push) stack_mem[top_reg] <= push_data;
  end

  assign pc        = pc_reg;
  assign ras_count = count_reg;
  assign ras_empty = stack_empty;
  assign ras_full  = stack_full;
  assign in_isr    = in_isr_reg;
  assign irq_ack   = irq_ack_reg;
  assign ovf       = ovf_reg;
  assign unf       = unf_reg;

endmodule

// File: tb/tb_pc_ras.sv
// Scoreboard bench for pc_ras: each step queues its expected outputs, which are
// popped and compared one cycle later once the DUT has registered the strobe.
module tb_pc_ras;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0, load = 1'b0, imm = 1'b0, call = 1'b0, ret = 1'b0;
  logic       reti = 1'b0, irq_req = 1'b0, clr_err = 1'b0;
  logic [7:0] target = '0;
  logic [7:0] pc;
  logic [2:0] ras_count;
  logic       ras_empty, ras_full, in_isr, irq_ack, ovf, unf;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    string      tag;
    logic [7:0] pc;
    int         cnt;
    logic [3:0] flags;  // {in_isr, irq_ack, ovf, unf}
  } exp_t;

  exp_t sb[$];

  pc_ras #(.AW(8), .DEPTH(4), .RESET_ADDR(0), .IRQ_VEC(32'hF0)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .load(load), .imm(imm), .call(call),
    .ret(ret), .reti(reti), .irq_req(irq_req), .clr_err(clr_err), .target(target),
    .pc(pc), .ras_count(ras_count), .ras_empty(ras_empty), .ras_full(ras_full),
    .in_isr(in_isr), .irq_ack(irq_ack), .ovf(ovf), .unf(unf)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic compare_outputs(input exp_t e);
    check_eq({e.tag, ".pc"}, 32'(pc), 32'(e.pc));
    check_eq({e.tag, ".cnt"}, 32'(ras_count), 32'(e.cnt));
    check_eq({e.tag, ".empty_full"}, {30'd0, ras_empty, ras_full},
             {30'd0, e.cnt == 0, e.cnt == 4});
    check_eq({e.tag, ".flags"}, {28'd0, in_isr, irq_ack, ovf, unf}, {28'd0, e.flags});
    $display("%-12s pc=%h cnt=%0d isr=%b ack=%b ovf=%b unf=%b",
             e.tag, pc, ras_count, in_isr, irq_ack, ovf, unf);
  endtask

  // Drive one cycle of strobes, queue the expected result, then compare after the edge.
  task automatic step(input string tag, input logic s_en, input logic s_load,
                      input logic s_imm, input logic s_call, input logic s_ret,
                      input logic s_reti, input logic s_irq, input logic s_clr,
                      input logic [7:0] s_tgt, input logic [7:0] e_pc, input int e_cnt,
                      input logic [3:0] e_flags);
    exp_t e;
    en = s_en; load = s_load; imm = s_imm; call = s_call; ret = s_ret;
    reti = s_reti; irq_req = s_irq; clr_err = s_clr; target = s_tgt;
    e.tag = tag; e.pc = e_pc; e.cnt = e_cnt; e.flags = e_flags;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check_eq({tag, ".sb_empty"}, 32'd0, 32'd1);
    end else begin
      compare_outputs(sb.pop_front());
    end
  endtask

  task automatic check_reset(input string tag);
    exp_t e;
    e.tag = tag; e.pc = 8'h00; e.cnt = 0; e.flags = 4'b0000;
    compare_outputs(e);
  endtask

  initial begin
    // Reset values while held in reset
    #3;
    check_reset("reset");
    @(posedge clk); @(posedge clk); #1;
    check_reset("reset_hold");
    rst_n = 1'b1;

    //     tag           en ld im cl rt ri ir cr tgt    pc     cnt flags
    step("seq_imm0",     1, 0, 0, 0, 0, 0, 0, 0, 8'h00, 8'h01, 0, 4'b0000);
    step("seq_imm1",     1, 0, 1, 0, 0, 0, 0, 0, 8'h00, 8'h03, 0, 4'b0000);
    step("seq_imm0b",    1, 0, 0, 0, 0, 0, 0, 0, 8'h00, 8'h04, 0, 4'b0000);

    step("ld_fe",        1, 1, 0, 0, 0, 0, 0, 0, 8'hFE, 8'hFE, 0, 4'b0000);
    step("wrap_imm1",    1, 0, 1, 0, 0, 0, 0, 0, 8'h00, 8'h00, 0, 4'b0000);
    step("wrap_imm0",    1, 0, 0, 0, 0, 0, 0, 0, 8'h00, 8'h01, 0, 4'b0000);

    step("ld_10",        1, 1, 0, 0, 0, 0, 0, 0, 8'd10,  8'd10, 0, 4'b0000);
    step("call_40",      1, 0, 1, 1, 0, 0, 0, 0, 8'd40,  8'd40, 1, 4'b0000);
    step("ret_12",       1, 0, 0, 0, 1, 0, 0, 0, 8'd0,   8'd12, 0, 4'b0000);

    // Five calls pushing 1..5; the fifth overwrites the oldest entry
    step("ld_0",         1, 1, 0, 0, 0, 0, 0, 0, 8'd0,   8'd0,  0, 4'b0000);
    for (int i = 1; i <= 5; i++) begin
      step($sformatf("call_%0d", i), 1, 0, 0, 1, 0, 0, 0, 0, 8'(i), 8'(i),
           (i > 4) ? 4 : i, (i > 4) ? 4'b0010 : 4'b0000);
    end
    for (int i = 0; i < 4; i++) begin
      step($sformatf("pop_%0d", i), 1, 0, 0, 0, 1, 0, 0, 0, 8'd0, 8'(5 - i), 3 - i, 4'b0010);
    end
    step("ret_unf",      1, 0, 0, 0, 1, 0, 0, 0, 8'd0,   8'd3,  0, 4'b0011);
    step("clr_err",      1, 0, 0, 0, 0, 0, 0, 1, 8'd0,   8'd4,  0, 4'b0000);
    // Clear and a fresh underflow in the same cycle: the flag ends set
    step("clr_and_unf",  1, 0, 0, 0, 1, 0, 0, 1, 8'd0,   8'd5,  0, 4'b0001);
    step("clr_err2",     1, 0, 0, 0, 0, 0, 0, 1, 8'd0,   8'd6,  0, 4'b0000);

    // Interrupt entry beats a simultaneous load; a second request is held off
    step("ld_20",        1, 1, 0, 0, 0, 0, 0, 0, 8'd20,  8'd20, 0, 4'b0000);
    step("irq_take",     1, 1, 0, 0, 0, 0, 1, 0, 8'd99,  8'hF0, 1, 4'b1100);
    step("irq_held",     1, 0, 0, 0, 0, 0, 1, 0, 8'd99,  8'hF1, 1, 4'b1000);
    step("reti",         1, 0, 0, 0, 0, 1, 0, 0, 8'd0,   8'd20, 0, 4'b0000);
    step("irq_again",    1, 0, 0, 0, 0, 0, 1, 0, 8'd0,   8'hF0, 1, 4'b1100);
    step("reti2",        1, 0, 0, 0, 0, 1, 0, 0, 8'd0,   8'd20, 0, 4'b0000);

    // Fill to overflow, then stall with strobes pulsing
    step("ld_0b",        1, 1, 0, 0, 0, 0, 0, 0, 8'd0,   8'd0,  0, 4'b0000);
    for (int i = 1; i <= 5; i++) begin
      step($sformatf("fill_%0d", i), 1, 0, 0, 1, 0, 0, 0, 0, 8'(i), 8'(i),
           (i > 4) ? 4 : i, (i > 4) ? 4'b0010 : 4'b0000);
    end
    step("stall_call",   0, 0, 0, 1, 0, 0, 0, 0, 8'd77,  8'd5,  4, 4'b0010);
    step("stall_ret",    0, 0, 0, 0, 1, 0, 0, 0, 8'd77,  8'd5,  4, 4'b0010);
    step("stall_irq",    0, 0, 0, 0, 0, 0, 1, 0, 8'd77,  8'd5,  4, 4'b0000 | 4'b0010);
    step("stall_clr",    0, 0, 0, 0, 0, 0, 1, 1, 8'd77,  8'd5,  4, 4'b0000);
    step("irq_full",     1, 0, 0, 0, 0, 0, 1, 0, 8'd0,   8'hF0, 4, 4'b1110);
    step("ack_stall",    0, 0, 0, 0, 0, 0, 1, 0, 8'd0,   8'hF0, 4, 4'b1010);
    step("reti_full",    1, 0, 0, 0, 0, 1, 0, 0, 8'd0,   8'd5,  3, 4'b0010);

    // Asynchronous reset mid-stream, away from any clock edge
    #2;
    rst_n = 1'b0;
    #1;
    check_reset("async_rst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    step("post_rst",     1, 0, 0, 0, 0, 0, 0, 0, 8'd0,   8'd1,  0, 4'b0000);

    check_eq("sb_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
